// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out transmitter with valid/ready word input
//
// Purpose:
//   Accepts a WIDTH-bit word when din_valid & din_ready. The word is then sent
//   one bit per clk on dout, framed by dout_valid. A new word can be accepted
//   on the final bit of a frame, so frames can follow each other with no idle gap.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   din         parallel word to transmit
//   din_valid   din holds a word to send
//   din_ready   combinational; high in IDLE or on the final bit of a frame
//   dout        serial data bit (registered)
//   dout_valid  dout carries a frame bit (registered)
//   frame_done  pulse coincident with the final frame bit (registered)
//
// Configuration:
//   PARITY_EN   when defined, an even-parity bit (XOR of the data bits) is
//               appended after the data bits, so the frame is WIDTH+1 bits long.

module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done
);

`ifdef PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             dout_q;
  logic             dout_valid_q;
  logic             frame_done_q;
  logic             last_bit;
  logic             accept;
  logic             next_bit;

  // The word is held intact and bits are selected by the counter; the counter
  // value names the bit currently on dout.
  function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] n);
    logic [IW-1:0] idx;
    if (MSB_FIRST != 0) idx = IW'(WIDTH - 1 - int'(n));
    else                idx = IW'(n);
    return w[idx];
  endfunction

  assign cnt_d     = cnt_q + CW'(1);
  assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign din_ready = !reset && ((state_q == IDLE) || last_bit);
  assign accept    = din_valid && din_ready;

  always_comb begin
    next_bit = pick_bit(shift_q, cnt_d);
`ifdef PARITY_EN
    // Slot after the last data bit carries even parity of the held word.
    if (cnt_d == CW'(WIDTH)) next_bit = ^shift_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (accept) begin
      // First bit is driven straight from din so it appears the cycle after accept.
      state_q      <= SHIFT;
      shift_q      <= din;
      cnt_q        <= '0;
      dout_q       <= pick_bit(din, '0);
      dout_valid_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_q      <= IDLE;
        dout_q       <= 1'b0;
        dout_valid_q <= 1'b0;
        frame_done_q <= 1'b0;
      end else begin
        cnt_q        <= cnt_d;
        dout_q       <= next_bit;
        dout_valid_q <= 1'b1;
        frame_done_q <= (cnt_d == LAST_CNT);
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;

endmodule
